// File: rtl/seg_scan_ctrl.sv
`timescale 1ns/1ps
// Eight-digit multiplexed seven-segment scan controller.
// Scans digits 0..7 at SCAN_DIV clocks per slot. New data/masks are staged on
// load and committed at the next frame boundary, so a frame never mixes old
// and new content. Digits can be blanked, given a decimal point, or made to
// blink with a period of BLINK_FRAMES frames per phase.
module seg_scan_ctrl #(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] data,
  input  logic [7:0]  blank_mask,
  input  logic [7:0]  dp_mask,
  input  logic [7:0]  blink_mask,
  output logic [7:0]  seg_out,
  output logic [7:0]  an_out,
  output logic        pending,
  output logic        frame_done
);

  localparam int unsigned   PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [7:0]    FRAME_LAST = 8'(BLINK_FRAMES - 1);

  typedef enum logic {
    PH_LIT  = 1'b0,
    PH_DARK = 1'b1
  } blink_ph_e;

  // Hex digit to active-low segments g..a.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Scan timing state
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    dig_q, dig_d;
  logic [7:0]    fcnt_q, fcnt_d;
  blink_ph_e     ph_q, ph_d;
  logic          fdone_q, fdone_d;
  logic          tick, boundary;

  // Staged and active display content
  logic [31:0]   stg_data_q, stg_data_d;
  logic [7:0]    stg_blank_q, stg_blank_d;
  logic [7:0]    stg_dp_q, stg_dp_d;
  logic [7:0]    stg_blink_q, stg_blink_d;
  logic [31:0]   act_data_q, act_data_d;
  logic [7:0]    act_blank_q, act_blank_d;
  logic [7:0]    act_dp_q, act_dp_d;
  logic [7:0]    act_blink_q, act_blink_d;
  logic          pend_q, pend_d;

  // Registered display drive
  logic [7:0]    seg_q, seg_d;
  logic [7:0]    an_q, an_d;
  logic [3:0]    nib;
  logic          dark;

  // Prescaler, digit index, frame pulse and blink phase
  always_comb begin
    tick     = en && (presc_q == PRESC_LAST);
    boundary = tick && (dig_q == 3'd7);
    presc_d  = presc_q;
    dig_d    = dig_q;
    fcnt_d   = fcnt_q;
    ph_d     = ph_q;
    fdone_d  = boundary;
    if (en) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
    if (tick) begin
      dig_d = dig_q + 3'd1;
    end
    if (boundary) begin
      if (fcnt_q == FRAME_LAST) begin
        fcnt_d = '0;
        ph_d   = (ph_q == PH_LIT) ? PH_DARK : PH_LIT;
      end else begin
        fcnt_d = fcnt_q + 8'd1;
      end
    end
  end

  // Staging and commit of data/masks; a load on the boundary bypasses staging
  always_comb begin
    stg_data_d  = stg_data_q;
    stg_blank_d = stg_blank_q;
    stg_dp_d    = stg_dp_q;
    stg_blink_d = stg_blink_q;
    act_data_d  = act_data_q;
    act_blank_d = act_blank_q;
    act_dp_d    = act_dp_q;
    act_blink_d = act_blink_q;
    pend_d      = pend_q;
    if (load) begin
      stg_data_d  = data;
      stg_blank_d = blank_mask;
      stg_dp_d    = dp_mask;
      stg_blink_d = blink_mask;
      pend_d      = 1'b1;
    end
    if (boundary) begin
      if (load) begin
        act_data_d  = data;
        act_blank_d = blank_mask;
        act_dp_d    = dp_mask;
        act_blink_d = blink_mask;
        pend_d      = 1'b0;
      end else if (pend_q) begin
        act_data_d  = stg_data_q;
        act_blank_d = stg_blank_q;
        act_dp_d    = stg_dp_q;
        act_blink_d = stg_blink_q;
        pend_d      = 1'b0;
      end
    end
  end

  // Output decode from next-state values so the new digit and any content
  // committed on the boundary appear together, one cycle after the tick
  always_comb begin
    nib = 4'h0;
    for (int unsigned k = 0; k < 8; k++) begin
      if (dig_d == 3'(k)) begin
        nib = act_data_d[4*k +: 4];
      end
    end
    dark  = act_blank_d[dig_d] || ((ph_d == PH_DARK) && act_blink_d[dig_d]);
    seg_d = '1;
    an_d  = '1;
    if (en && !dark) begin
      an_d  = ~(8'h01 << dig_d);
      seg_d = {~act_dp_d[dig_d], hex7(nib)};
    end
  end

  // State registers with asynchronous reset to a dark, empty display
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q     <= '0;
      dig_q       <= '0;
      fcnt_q      <= '0;
      ph_q        <= PH_LIT;
      fdone_q     <= 1'b0;
      stg_data_q  <= '0;
      stg_blank_q <= '1;
      stg_dp_q    <= '0;
      stg_blink_q <= '0;
      act_data_q  <= '0;
      act_blank_q <= '1;
      act_dp_q    <= '0;
      act_blink_q <= '0;
      pend_q      <= 1'b0;
      seg_q       <= '1;
      an_q        <= '1;
    end else begin
      presc_q     <= presc_d;
      dig_q       <= dig_d;
      fcnt_q      <= fcnt_d;
      ph_q        <= ph_d;
      fdone_q     <= fdone_d;
      stg_data_q  <= stg_data_d;
      stg_blank_q <= stg_blank_d;
      stg_dp_q    <= stg_dp_d;
      stg_blink_q <= stg_blink_d;
      act_data_q  <= act_data_d;
      act_blank_q <= act_blank_d;
      act_dp_q    <= act_dp_d;
      act_blink_q <= act_blink_d;
      pend_q      <= pend_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign seg_out    = seg_q;
  assign an_out     = an_q;
  assign pending    = pend_q;
  assign frame_done = fdone_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for seg_scan_ctrl with SCAN_DIV=4, BLINK_FRAMES=2.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [31:0] data = '0;
  logic [7:0]  blank_mask = '0;
  logic [7:0]  dp_mask = '0;
  logic [7:0]  blink_mask = '0;
  logic [7:0]  seg_out;
  logic [7:0]  an_out;
  logic        pending;
  logic        frame_done;

  seg_scan_ctrl #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .data(data),
    .blank_mask(blank_mask), .dp_mask(dp_mask), .blink_mask(blink_mask),
    .seg_out(seg_out), .an_out(an_out), .pending(pending), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] seg;
    logic [7:0] an;
    logic       pend;
    logic       fd;
    string      tag;
  } exp_t;

  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  string phase = "reset";
  event  chk_ev;

  // Per-frame expectations, packed {digit7 .. digit0}
  localparam logic [63:0] SEG_A  = 64'hF8829299B0A4F9C0; // data 76543210
  localparam logic [63:0] SEG_C  = 64'hC0F9A4B0999282F8; // data 01234567
  localparam logic [63:0] SEG_F  = 64'h8E8E8E8E8E8E8E8E; // data FFFFFFFF
  localparam logic [63:0] AN_N   = 64'h7FBFDFEFF7FBFDFE;
  localparam logic [63:0] SEG_DD = 64'hF8829299B0FF79FF; // masks, blink dark
  localparam logic [63:0] AN_DD  = 64'h7FBFDFEFF7FFFDFF;
  localparam logic [63:0] SEG_DL = 64'hF8829299B0A479FF; // masks, blink lit
  localparam logic [63:0] AN_DL  = 64'h7FBFDFEFF7FBFDFF;

  // Monitor: one expectation per falling edge, or an immediate one on chk_ev
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or chk_ev);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (seg_out !== e.seg || an_out !== e.an || pending !== e.pend || frame_done !== e.fd) begin
          errors++;
          $display("FAIL %s @%0t: got seg_out=%h an_out=%h pending=%b frame_done=%b, expected seg_out=%h an_out=%h pending=%b frame_done=%b",
                   e.tag, $time, seg_out, an_out, pending, frame_done, e.seg, e.an, e.pend, e.fd);
        end
      end
    end
  end

  task automatic cyc(input logic [7:0] s, input logic [7:0] a, input logic p, input logic f);
    @(posedge clk);
    exp_q.push_back('{seg: s, an: a, pend: p, fd: f, tag: phase});
    #1;
  endtask

  task automatic slot(input logic [7:0] s, input logic [7:0] a, input logic p, input logic f);
    cyc(s, a, p, f);
    repeat (3) cyc(s, a, p, 1'b0);
  endtask

  task automatic slot_of(input logic [63:0] segs, input logic [63:0] ans, input int k,
                         input logic p, input logic f);
    slot(segs[8*k +: 8], ans[8*k +: 8], p, f);
  endtask

  task automatic frame(input logic [63:0] segs, input logic [63:0] ans, input logic p);
    for (int k = 0; k < 8; k++) slot_of(segs, ans, k, p, (k == 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected completion before 200000ns");
    $fatal(1);
  end

  initial begin
    repeat (3) cyc(8'hFF, 8'hFF, 1'b0, 1'b0);

    rst = 1'b0; en = 1'b1; load = 1'b1; data = 32'h76543210;
    phase = "first_load";
    cyc(8'hFF, 8'hFF, 1'b1, 1'b0);
    load = 1'b0;
    repeat (30) cyc(8'hFF, 8'hFF, 1'b1, 1'b0);
    phase = "frame_digits";
    frame(SEG_A, AN_N, 1'b0);

    phase = "mid_load";
    slot_of(SEG_A, AN_N, 0, 1'b0, 1'b1);
    slot_of(SEG_A, AN_N, 1, 1'b0, 1'b0);
    cyc(8'hA4, 8'hFB, 1'b0, 1'b0);
    cyc(8'hA4, 8'hFB, 1'b0, 1'b0);
    load = 1'b1; data = 32'hFFFFFFFF;
    cyc(8'hA4, 8'hFB, 1'b1, 1'b0);
    load = 1'b0;
    cyc(8'hA4, 8'hFB, 1'b1, 1'b0);
    for (int k = 3; k < 8; k++) slot_of(SEG_A, AN_N, k, 1'b1, 1'b0);
    phase = "staged_commit";
    frame(SEG_F, AN_N, 1'b0);

    phase = "load_at_boundary";
    load = 1'b1; data = 32'h01234567;
    cyc(8'hF8, 8'hFE, 1'b0, 1'b1);
    load = 1'b0;
    repeat (3) cyc(8'hF8, 8'hFE, 1'b0, 1'b0);
    for (int k = 1; k < 8; k++) slot_of(SEG_C, AN_N, k, 1'b0, 1'b0);

    phase = "mask_load";
    cyc(8'hF8, 8'hFE, 1'b0, 1'b1);
    load = 1'b1; data = 32'h76543210;
    blank_mask = 8'h01; dp_mask = 8'h02; blink_mask = 8'h04;
    cyc(8'hF8, 8'hFE, 1'b1, 1'b0);
    load = 1'b0;
    repeat (2) cyc(8'hF8, 8'hFE, 1'b1, 1'b0);
    for (int k = 1; k < 8; k++) slot_of(SEG_C, AN_N, k, 1'b1, 1'b0);
    phase = "blink_dark";
    frame(SEG_DD, AN_DD, 1'b0);
    frame(SEG_DD, AN_DD, 1'b0);
    phase = "blink_lit";
    frame(SEG_DL, AN_DL, 1'b0);
    frame(SEG_DL, AN_DL, 1'b0);

    phase = "en_hold";
    slot(8'hFF, 8'hFF, 1'b0, 1'b1);
    slot(8'h79, 8'hFD, 1'b0, 1'b0);
    slot(8'hFF, 8'hFF, 1'b0, 1'b0);
    cyc(8'hB0, 8'hF7, 1'b0, 1'b0);
    cyc(8'hB0, 8'hF7, 1'b0, 1'b0);
    en = 1'b0;
    repeat (10) cyc(8'hFF, 8'hFF, 1'b0, 1'b0);
    en = 1'b1;
    cyc(8'hB0, 8'hF7, 1'b0, 1'b0);
    cyc(8'hB0, 8'hF7, 1'b0, 1'b0);
    slot(8'h99, 8'hEF, 1'b0, 1'b0);
    slot(8'h92, 8'hDF, 1'b0, 1'b0);
    slot(8'h82, 8'hBF, 1'b0, 1'b0);
    slot(8'hF8, 8'h7F, 1'b0, 1'b0);

    phase = "async_reset";
    cyc(8'hFF, 8'hFF, 1'b0, 1'b1);
    load = 1'b1; data = 32'hFFFFFFFF;
    blank_mask = 8'h00; dp_mask = 8'h00; blink_mask = 8'h00;
    cyc(8'hFF, 8'hFF, 1'b1, 1'b0);
    load = 1'b0;
    cyc(8'hFF, 8'hFF, 1'b1, 1'b0);
    cyc(8'hFF, 8'hFF, 1'b1, 1'b0);
    cyc(8'h79, 8'hFD, 1'b1, 1'b0);
    cyc(8'h79, 8'hFD, 1'b1, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    exp_q.push_back('{seg: 8'hFF, an: 8'hFF, pend: 1'b0, fd: 1'b0, tag: "async_reset_immediate"});
    -> chk_ev;
    repeat (2) cyc(8'hFF, 8'hFF, 1'b0, 1'b0);
    rst = 1'b0;

    phase = "after_reset";
    repeat (31) cyc(8'hFF, 8'hFF, 1'b0, 1'b0);
    cyc(8'hFF, 8'hFF, 1'b0, 1'b1);
    load = 1'b1; data = 32'h76543210;
    cyc(8'hFF, 8'hFF, 1'b1, 1'b0);
    load = 1'b0;
    repeat (30) cyc(8'hFF, 8'hFF, 1'b1, 1'b0);
    phase = "reload_after_reset";
    frame(SEG_A, AN_N, 1'b0);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 100000, clock cycles per digit slot (legal range 2..2^20).
REQ-002 Parameter BLINK_FRAMES, default 64, full frames per blink phase (legal range 1..255).
REQ-003 Port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port en  input  1  scan enable; 0 = display dark, counters held.
REQ-006 Port load  input  1  one-cycle strobe that stages data and masks.
REQ-007 Port data  input  32  eight hex nibbles; nibble k = data[4k+3:4k] is shown on digit k.
REQ-008 Port blank_mask  input  8  bit k = 1 blanks digit k.
REQ-009 Port dp_mask  input  8  bit k = 1 lights the decimal point of digit k.
REQ-010 Port blink_mask  input  8  bit k = 1 makes digit k blink.
REQ-011 Port seg_out  output  8  active-low segments; bit7 = dp, bits6:0 = g..a.
REQ-012 Port an_out  output  8  active-low digit enables, one-hot-low or all-high.
REQ-013 Port pending  output  1  staged values are waiting for the next frame boundary.
REQ-014 Port frame_done  output  1  one-cycle pulse at each digit-7-to-digit-0 wrap.

Function
REQ-015 The prescaler SHALL count 0..SCAN_DIV-1 while en=1, assert an internal tick in the cycle it equals SCAN_DIV-1, and wrap to 0.
REQ-016 The digit index SHALL advance 0->1->...->7->0 on each tick; the 7->0 step is a frame boundary.
REQ-017 frame_done SHALL be 1 for exactly the cycle after the boundary tick, and 0 otherwise.
REQ-018 load=1 SHALL copy data and all three masks into staging registers and set pending=1 on the next edge; a later load before the boundary overwrites the staged values.
REQ-019 At a frame boundary with pending=1, staging SHALL be copied to the active registers and pending SHALL clear on the same edge.
REQ-020 If load and a boundary tick coincide, the active registers SHALL take the load inputs directly, and pending SHALL end 0.
REQ-021 seg_out and an_out SHALL be registered and reflect the new digit index one cycle after the tick (latency 1).
REQ-022 For a visible digit k: an_out = 8'hFF with bit k cleared; seg_out[6:0] = hex encoding of nibble k; seg_out[7] = ~dp_mask[k].
REQ-023 Hex encoding (seg_out with dp off), digits 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
REQ-024 Digit k SHALL be dark (an_out = FF, seg_out = FF) when the active blank_mask[k]=1, or when blink phase=1 and the active blink_mask[k]=1.
REQ-025 The blink phase SHALL toggle after every BLINK_FRAMES frame boundaries, using an 8-bit frame counter that wraps to 0 on each toggle.
REQ-026 While en=0: an_out=FF and seg_out=FF from the next edge; prescaler, digit index and blink state are held; load and staging still work; no boundary occurs.
REQ-027 When en rises, scanning SHALL resume from the held prescaler value and digit index, with no extra frame_done.

Reset
REQ-028 When rst=1, the block SHALL set seg_out=FF, an_out=FF, pending=0, frame_done=0, prescaler=0, digit index=0, blink phase=0 and frame counter=0, regardless of clk.
REQ-029 Reset SHALL clear the active and staging data and the dp and blink masks to 0, and set both blank_mask copies to FF, so the display stays dark until the first load.
REQ-030 A reset asserted mid-frame or while pending=1 SHALL discard the staged values; the first tick after release comes SCAN_DIV cycles after rst falls.

Verification (SCAN_DIV=4, BLINK_FRAMES=2)
REQ-031 Reset, load data=32'h76543210 with all masks 0, en=1 -> after the first boundary, digit k shows k (digit0 C0, digit1 F9, ...), each digit for 4 cycles, with an_out walking FE,FD,...,7F.
REQ-032 Load data=32'hFFFFFFFF mid-frame -> pending=1 and the old values keep showing until the boundary; frame_done pulses, pending falls, and digit 0 shows 8E.
REQ-033 Load in the exact cycle of the boundary tick -> new values are shown from digit 0 of that frame, and pending is never observed as 1 afterwards.
REQ-034 blank_mask=8'h01, dp_mask=8'h02, blink_mask=8'h04 -> digit0 dark, digit1 shows seg_out bit7=0, digit2 alternates between lit for 2 frames and dark for 2 frames.
REQ-035 en=0 for 10 cycles mid-frame -> outputs FF and no frame_done; after en=1, the same digit continues, and the frame period excluding the hold is 32 cycles.
REQ-036 Assert rst asynchronously between clock edges with pending=1 -> outputs FF immediately, pending=0, and the display stays dark until a new load reaches a boundary.
